// File: rtl/mips_pkg.sv
// Shared constants for the MIPS multicycle controller: ALU select codes,
// opcode/funct encodings, FSM states and ALU decode classes.
package mips_pkg;

    localparam int unsigned ALU_SEL_W = 5;
    localparam int unsigned OP_W      = 6;

    localparam logic [ALU_SEL_W-1:0] ALU_AND  = 5'b00000;
    localparam logic [ALU_SEL_W-1:0] ALU_OR   = 5'b00001;
    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 5'b00010;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 5'b00100;
    localparam logic [ALU_SEL_W-1:0] ALU_NOR  = 5'b00101;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 5'b00110;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT  = 5'b00111;
    localparam logic [ALU_SEL_W-1:0] ALU_SLL  = 5'b01000;
    localparam logic [ALU_SEL_W-1:0] ALU_SRL  = 5'b01001;
    localparam logic [ALU_SEL_W-1:0] ALU_SRA  = 5'b01010;
    localparam logic [ALU_SEL_W-1:0] ALU_SLTU = 5'b01011;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [OP_W-1:0] FN_SLL  = 6'b000000;
    localparam logic [OP_W-1:0] FN_SRL  = 6'b000010;
    localparam logic [OP_W-1:0] FN_SRA  = 6'b000011;
    localparam logic [OP_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;
    localparam logic [OP_W-1:0] FN_AND  = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR   = 6'b100101;
    localparam logic [OP_W-1:0] FN_XOR  = 6'b100110;
    localparam logic [OP_W-1:0] FN_NOR  = 6'b100111;
    localparam logic [OP_W-1:0] FN_SLT  = 6'b101010;
    localparam logic [OP_W-1:0] FN_SLTU = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    // Which decode table drives alu_sel in the current state
    typedef enum logic [1:0] {
        CLS_ADD, CLS_SUB, CLS_R, CLS_I
    } alu_cls_t;

endpackage

// File: rtl/alu_sel_decode.sv
// Combinational ALU select decode: (state class, opcode, funct) to
// alu_sel, immediate extension mode and instruction legality.
module alu_sel_decode
    import mips_pkg::*;
(
    input  alu_cls_t             cls,
    input  logic [OP_W-1:0]      opcode,
    input  logic [OP_W-1:0]      funct,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 imm_zext,
    output logic                 legal
);

    logic [ALU_SEL_W-1:0] r_sel;
    logic [ALU_SEL_W-1:0] i_sel;
    logic                 r_ok;
    logic                 i_ok;
    logic                 i_zext;

    always_comb begin
        r_sel = ALU_ADD;
        r_ok  = 1'b1;
        case (funct)
            FN_ADD, FN_ADDU: r_sel = ALU_ADD;
            FN_SUB, FN_SUBU: r_sel = ALU_SUB;
            FN_AND:          r_sel = ALU_AND;
            FN_OR:           r_sel = ALU_OR;
            FN_XOR:          r_sel = ALU_XOR;
            FN_NOR:          r_sel = ALU_NOR;
            FN_SLT:          r_sel = ALU_SLT;
            FN_SLTU:         r_sel = ALU_SLTU;
            FN_SLL:          r_sel = ALU_SLL;
            FN_SRL:          r_sel = ALU_SRL;
            FN_SRA:          r_sel = ALU_SRA;
            default:         r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        i_sel  = ALU_ADD;
        i_ok   = 1'b1;
        i_zext = 1'b0;
        case (opcode)
            OP_ADDI, OP_ADDIU: i_sel = ALU_ADD;
            OP_ANDI:  begin i_sel = ALU_AND; i_zext = 1'b1; end
            OP_ORI:   begin i_sel = ALU_OR;  i_zext = 1'b1; end
            OP_XORI:  begin i_sel = ALU_XOR; i_zext = 1'b1; end
            OP_SLTI:  i_sel = ALU_SLT;
            OP_SLTIU: i_sel = ALU_SLTU;
            default:  i_ok  = 1'b0;
        endcase
    end

    always_comb begin
        legal = i_ok;
        case (opcode)
            OP_RTYPE:                        legal = r_ok;
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
            default:                         legal = i_ok;
        endcase
    end

    always_comb begin
        alu_sel  = ALU_ADD;
        imm_zext = 1'b0;
        case (cls)
            CLS_SUB: alu_sel = ALU_SUB;
            CLS_R:   alu_sel = r_sel;
            CLS_I:   begin alu_sel = i_sel; imm_zext = i_zext; end
            default: alu_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives ALU select, datapath muxes, strobes and the memory handshake.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_W-1:0]      opcode,
    input  logic [OP_W-1:0]      funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 imm_zext,
    output logic [1:0]           pc_src,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 illegal_instr,
    output logic                 bus_error,
    output logic [31:0]          instr_count
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t               state;
    state_t               state_nx;
    logic [WAIT_W-1:0]    wait_cnt;
    alu_cls_t             cls;
    logic [ALU_SEL_W-1:0] dec_sel;
    logic                 dec_zext;
    logic                 dec_legal;
    logic                 waiting_c;
    logic                 timeout_c;
    logic                 retire_c;

    assign cls = (state == S_EXEC_R) ? CLS_R :
                 (state == S_EXEC_I) ? CLS_I :
                 (state == S_BRANCH) ? CLS_SUB : CLS_ADD;

    alu_sel_decode u_alu_sel_decode (
        .cls      (cls),
        .opcode   (opcode),
        .funct    (funct),
        .alu_sel  (dec_sel),
        .imm_zext (dec_zext),
        .legal    (dec_legal)
    );

    // Next state and per-state outputs; reset masks every strobe
    always_comb begin
        state_nx   = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        retire_c   = 1'b0;
        alu_sel    = dec_sel;
        imm_zext   = dec_zext;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (!dec_legal) begin
                    state_nx = S_TRAP;
                end else begin
                    case (opcode)
                        OP_RTYPE:      state_nx = S_EXEC_R;
                        OP_LW, OP_SW:  state_nx = S_MEM_ADDR;
                        OP_BEQ, OP_BNE: state_nx = S_BRANCH;
                        OP_J:          state_nx = S_JUMP;
                        default:       state_nx = S_EXEC_I;
                    endcase
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                state_nx  = S_WB_R;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_nx  = S_WB_I;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire_c  = 1'b1;
                state_nx  = S_FETCH;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                retire_c  = 1'b1;
                state_nx  = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_nx  = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_nx = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    retire_c = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire_c   = 1'b1;
                state_nx   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                pc_src    = 2'b01;
                pc_write  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
                retire_c  = 1'b1;
                state_nx  = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                retire_c = 1'b1;
                state_nx = S_FETCH;
            end
            S_TRAP:  state_nx = S_TRAP;
            default: state_nx = S_FETCH;
        endcase

        waiting_c = mem_req && !mem_ready;
        timeout_c = (MEM_TIMEOUT != 0) && waiting_c &&
                    (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
        if (timeout_c) state_nx = S_TRAP;

        if (!rst_n) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_src     = 2'b00;
            imm_zext   = 1'b0;
            alu_sel    = ALU_ADD;
            retire_c   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_FETCH;
            wait_cnt      <= '0;
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
            instr_count   <= '0;
        end else begin
            state <= state_nx;
            // Waiting never coincides with a state change except on timeout
            if (waiting_c && !timeout_c) wait_cnt <= wait_cnt + WAIT_W'(1);
            else                         wait_cnt <= '0;
            if ((state == S_DECODE) && !dec_legal) illegal_instr <= 1'b1;
            if (timeout_c)                         bus_error     <= 1'b1;
            if (retire_c) instr_count <= instr_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: the driver queues hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'b0;
    logic [5:0]  funct = 6'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write;
    logic        reg_dst, mem_to_reg, alu_src_a, imm_zext;
    logic [1:0]  alu_src_b, pc_src;
    logic [4:0]  alu_sel;
    logic        illegal_instr, bus_error;
    logic [31:0] instr_count;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_zext      (imm_zext),
        .pc_src        (pc_src),
        .alu_sel       (alu_sel),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .instr_count   (instr_count)
    );

    // {mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst,
    //  mem_to_reg, alu_src_a, alu_src_b, imm_zext, pc_src, alu_sel}
    function automatic logic [18:0] mk(input logic rq, we, io, irw, pcw, rw, rd, m2r, sa,
                                       input logic [1:0] sb, input logic zx,
                                       input logic [1:0] ps, input logic [4:0] sel);
        return {rq, we, io, irw, pcw, rw, rd, m2r, sa, sb, zx, ps, sel};
    endfunction

    localparam logic [1:0] B00 = 2'b00, B01 = 2'b01, B10 = 2'b10, B11 = 2'b11;
    localparam logic O = 1'b0, I = 1'b1;

    localparam logic [18:0] C_IDLE     = mk(O,O,O,O,O,O,O,O,O,B00,O,B00,5'b00010);
    localparam logic [18:0] C_FETCH_W  = mk(I,O,O,O,O,O,O,O,O,B01,O,B00,5'b00010);
    localparam logic [18:0] C_FETCH_R  = mk(I,O,O,I,I,O,O,O,O,B01,O,B00,5'b00010);
    localparam logic [18:0] C_DECODE   = mk(O,O,O,O,O,O,O,O,O,B11,O,B00,5'b00010);
    localparam logic [18:0] C_EXR_ADD  = mk(O,O,O,O,O,O,O,O,I,B00,O,B00,5'b00010);
    localparam logic [18:0] C_EXR_SRA  = mk(O,O,O,O,O,O,O,O,I,B00,O,B00,5'b01010);
    localparam logic [18:0] C_EXI_AND  = mk(O,O,O,O,O,O,O,O,I,B10,I,B00,5'b00000);
    localparam logic [18:0] C_EXI_SLTU = mk(O,O,O,O,O,O,O,O,I,B10,O,B00,5'b01011);
    localparam logic [18:0] C_WB_R     = mk(O,O,O,O,O,I,I,O,O,B00,O,B00,5'b00010);
    localparam logic [18:0] C_WB_I     = mk(O,O,O,O,O,I,O,O,O,B00,O,B00,5'b00010);
    localparam logic [18:0] C_MADDR    = mk(O,O,O,O,O,O,O,O,I,B10,O,B00,5'b00010);
    localparam logic [18:0] C_MRD      = mk(I,O,I,O,O,O,O,O,O,B00,O,B00,5'b00010);
    localparam logic [18:0] C_MWR      = mk(I,I,I,O,O,O,O,O,O,B00,O,B00,5'b00010);
    localparam logic [18:0] C_WBM      = mk(O,O,O,O,O,I,O,I,O,B00,O,B00,5'b00010);
    localparam logic [18:0] C_BR_T     = mk(O,O,O,O,I,O,O,O,I,B00,O,B01,5'b00110);
    localparam logic [18:0] C_BR_N     = mk(O,O,O,O,O,O,O,O,I,B00,O,B01,5'b00110);
    localparam logic [18:0] C_JUMP     = mk(O,O,O,O,I,O,O,O,O,B00,O,B10,5'b00010);

    typedef struct {
        logic [18:0] ctl;
        logic        ill;
        logic        bus;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic        drain_req = 1'b0;
    logic        drain_done = 1'b0;
    logic [18:0] act_ctl;

    assign act_ctl = {mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst,
                      mem_to_reg, alu_src_a, alu_src_b, imm_zext, pc_src, alu_sel};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act_ctl !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl: got %b expected %b", e.name, act_ctl, e.ctl);
            end
            checks++;
            if ({illegal_instr, bus_error, instr_count} !== {e.ill, e.bus, e.cnt}) begin
                errors++;
                $display("FAIL %s status: got ill=%b bus=%b cnt=%0d expected ill=%b bus=%b cnt=%0d",
                         e.name, illegal_instr, bus_error, instr_count, e.ill, e.bus, e.cnt);
            end
        end else if (drain_req && !drain_done) begin
            checks++;
            drain_done = 1'b1;
        end
    end

    task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input logic [18:0] ctl,
                        input logic ill, input logic bus, input logic [31:0] cnt,
                        input string nm);
        @(posedge clk);
        #1;
        rst_n     = rst;
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = rdy;
        exp_q.push_back('{ctl: ctl, ill: ill, bus: bus, cnt: cnt, name: nm});
    endtask

    initial begin
        step(O, 6'b000000, 6'b100000, O, I, C_IDLE,     O, O, 0, "reset");
        // add: 4 cycles
        step(I, 6'b000000, 6'b100000, O, I, C_FETCH_R,  O, O, 0, "add_fetch");
        step(I, 6'b000000, 6'b100000, O, I, C_DECODE,   O, O, 0, "add_decode");
        step(I, 6'b000000, 6'b100000, O, I, C_EXR_ADD,  O, O, 0, "add_exec");
        step(I, 6'b000000, 6'b100000, O, I, C_WB_R,     O, O, 0, "add_wb");
        // lw with three wait cycles: 8 cycles
        step(I, 6'b100011, 6'b000000, O, I, C_FETCH_R,  O, O, 1, "lw_fetch");
        step(I, 6'b100011, 6'b000000, O, O, C_DECODE,   O, O, 1, "lw_decode");
        step(I, 6'b100011, 6'b000000, O, O, C_MADDR,    O, O, 1, "lw_addr");
        step(I, 6'b100011, 6'b000000, O, O, C_MRD,      O, O, 1, "lw_wait1");
        step(I, 6'b100011, 6'b000000, O, O, C_MRD,      O, O, 1, "lw_wait2");
        step(I, 6'b100011, 6'b000000, O, O, C_MRD,      O, O, 1, "lw_wait3");
        step(I, 6'b100011, 6'b000000, O, I, C_MRD,      O, O, 1, "lw_rd");
        step(I, 6'b100011, 6'b000000, O, I, C_WBM,      O, O, 1, "lw_wb");
        // branches
        step(I, 6'b000100, 6'b000000, I, I, C_FETCH_R,  O, O, 2, "beq_fetch");
        step(I, 6'b000100, 6'b000000, I, I, C_DECODE,   O, O, 2, "beq_decode");
        step(I, 6'b000100, 6'b000000, I, I, C_BR_T,     O, O, 2, "beq_z1");
        step(I, 6'b000101, 6'b000000, I, I, C_FETCH_R,  O, O, 3, "bne_fetch");
        step(I, 6'b000101, 6'b000000, I, I, C_DECODE,   O, O, 3, "bne_decode");
        step(I, 6'b000101, 6'b000000, I, I, C_BR_N,     O, O, 3, "bne_z1");
        step(I, 6'b000101, 6'b000000, O, I, C_FETCH_R,  O, O, 4, "bne2_fetch");
        step(I, 6'b000101, 6'b000000, O, I, C_DECODE,   O, O, 4, "bne2_decode");
        step(I, 6'b000101, 6'b000000, O, I, C_BR_T,     O, O, 4, "bne_z0");
        // sra, andi, sltiu
        step(I, 6'b000000, 6'b000011, O, I, C_FETCH_R,  O, O, 5, "sra_fetch");
        step(I, 6'b000000, 6'b000011, O, I, C_DECODE,   O, O, 5, "sra_decode");
        step(I, 6'b000000, 6'b000011, O, I, C_EXR_SRA,  O, O, 5, "sra_exec");
        step(I, 6'b000000, 6'b000011, O, I, C_WB_R,     O, O, 5, "sra_wb");
        step(I, 6'b001100, 6'b000000, O, I, C_FETCH_R,  O, O, 6, "andi_fetch");
        step(I, 6'b001100, 6'b000000, O, I, C_DECODE,   O, O, 6, "andi_decode");
        step(I, 6'b001100, 6'b000000, O, I, C_EXI_AND,  O, O, 6, "andi_exec");
        step(I, 6'b001100, 6'b000000, O, I, C_WB_I,     O, O, 6, "andi_wb");
        step(I, 6'b001011, 6'b000000, O, I, C_FETCH_R,  O, O, 7, "sltiu_fetch");
        step(I, 6'b001011, 6'b000000, O, I, C_DECODE,   O, O, 7, "sltiu_decode");
        step(I, 6'b001011, 6'b000000, O, I, C_EXI_SLTU, O, O, 7, "sltiu_exec");
        step(I, 6'b001011, 6'b000000, O, I, C_WB_I,     O, O, 7, "sltiu_wb");
        // j
        step(I, 6'b000010, 6'b000000, O, I, C_FETCH_R,  O, O, 8, "j_fetch");
        step(I, 6'b000010, 6'b000000, O, I, C_DECODE,   O, O, 8, "j_decode");
        step(I, 6'b000010, 6'b000000, O, I, C_JUMP,     O, O, 8, "j_jump");
        // sw zero-wait
        step(I, 6'b101011, 6'b000000, O, I, C_FETCH_R,  O, O, 9, "sw_fetch");
        step(I, 6'b101011, 6'b000000, O, I, C_DECODE,   O, O, 9, "sw_decode");
        step(I, 6'b101011, 6'b000000, O, I, C_MADDR,    O, O, 9, "sw_addr");
        step(I, 6'b101011, 6'b000000, O, I, C_MWR,      O, O, 9, "sw_wr");
        // sw interrupted by reset mid-MEM_WR
        step(I, 6'b101011, 6'b000000, O, I, C_FETCH_R,  O, O, 10, "sw2_fetch");
        step(I, 6'b101011, 6'b000000, O, I, C_DECODE,   O, O, 10, "sw2_decode");
        step(I, 6'b101011, 6'b000000, O, O, C_MADDR,    O, O, 10, "sw2_addr");
        step(I, 6'b101011, 6'b000000, O, O, C_MWR,      O, O, 10, "sw2_wait");
        step(O, 6'b101011, 6'b000000, O, I, C_IDLE,     O, O, 10, "sw2_rst");
        // illegal opcode
        step(I, 6'b111111, 6'b000000, O, O, C_FETCH_W,  O, O, 0, "post_rst_fetch");
        step(I, 6'b111111, 6'b000000, O, I, C_FETCH_R,  O, O, 0, "ill_fetch");
        step(I, 6'b111111, 6'b000000, O, I, C_DECODE,   O, O, 0, "ill_decode");
        step(I, 6'b111111, 6'b000000, O, I, C_IDLE,     I, O, 0, "ill_trap");
        step(I, 6'b000000, 6'b100000, O, I, C_IDLE,     I, O, 0, "ill_hold");
        step(O, 6'b000000, 6'b000001, O, I, C_IDLE,     I, O, 0, "ill_rst");
        // illegal R-type funct
        step(I, 6'b000000, 6'b000001, O, I, C_FETCH_R,  O, O, 0, "badfn_fetch");
        step(I, 6'b000000, 6'b000001, O, I, C_DECODE,   O, O, 0, "badfn_decode");
        step(I, 6'b000000, 6'b000001, O, I, C_IDLE,     I, O, 0, "badfn_trap");
        step(O, 6'b000000, 6'b100000, O, O, C_IDLE,     I, O, 0, "badfn_rst");
        // fetch timeout after four wait cycles
        step(I, 6'b000000, 6'b100000, O, O, C_FETCH_W,  O, O, 0, "to_wait1");
        step(I, 6'b000000, 6'b100000, O, O, C_FETCH_W,  O, O, 0, "to_wait2");
        step(I, 6'b000000, 6'b100000, O, O, C_FETCH_W,  O, O, 0, "to_wait3");
        step(I, 6'b000000, 6'b100000, O, O, C_FETCH_W,  O, O, 0, "to_wait4");
        step(I, 6'b000000, 6'b100000, O, O, C_IDLE,     O, I, 0, "to_trap");
        step(I, 6'b000000, 6'b100000, O, I, C_IDLE,     O, I, 0, "to_hold");
        step(O, 6'b000000, 6'b100000, O, O, C_IDLE,     O, I, 0, "to_rst");
        step(I, 6'b000000, 6'b100000, O, O, C_FETCH_W,  O, O, 0, "to_clear");

        drain_req = 1'b1;
        for (int i = 0; i < 20 && !drain_done; i++) @(posedge clk);
        if (!drain_done) begin
            $display("FAIL drain: got %0d queued expected 0", exp_q.size());
            $fatal(1, "scoreboard did not drain");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM for the MIPS datapath, and the driving end of the ALU select interface. It decodes the instruction register (opcode/funct) and sequences fetch, decode, execute, memory and writeback. Each cycle it issues the 5-bit ALU select code, operand-mux selects, register, PC and memory strobes, and a memory request/ready handshake. It sits between the instruction register and the shared datapath (ALU, register file, single-ported memory).

## Interface
- MEM_TIMEOUT, 255: max cycles to wait for mem_ready before bus error; 0 disables the timeout.
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  synchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req / mem_we  out  1/1  memory access request / write
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write, pc_write, reg_write  out  1 each  write strobes
- reg_dst  out  1  destination register: 1 = rd, 0 = rt
- mem_to_reg  out  1  writeback source: 1 = MDR, 0 = ALUOut
- alu_src_a  out  1  ALU operand A: 0 = PC, 1 = A
- alu_src_b  out  2  ALU operand B: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- imm_zext  out  1  overrides 10 with zero-extended imm
- pc_src  out  2  next PC: 00 = ALU y, 01 = ALUOut, 10 = jump target
- alu_sel  out  5  ALU select code
- illegal_instr, bus_error  out  1 each  sticky fault flags
- instr_count  out  32  retired-instruction counter

## Operation
- ALU select codes:
  - AND 00000, OR 00001, ADD 00010, XOR 00100, NOR 00101, SUB 00110
  - SLT 00111, SLL 01000, SRL 01001, SRA 01010, SLTU 01011
- States: FETCH, DECODE, EXEC_R, EXEC_I, WB_R, WB_I, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, JUMP, TRAP.
- FETCH: mem_req=1, iord=0, alu ADD, src_a=PC, src_b=01, pc_src=00. On mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
- DECODE: alu ADD, src_a=PC, src_b=11 (branch target into ALUOut). Next state by opcode:
  - 000000 → EXEC_R if funct is legal
  - lw 100011, sw 101011 → MEM_ADDR
  - beq 000100, bne 000101 → BRANCH
  - j 000010 → JUMP
  - addi/addiu/andi/ori/xori/slti/sltiu → EXEC_I
  - anything else → TRAP with illegal_instr set
- EXEC_R: src_a=1, src_b=00. funct → sel:
  - 100000/100001 ADD, 100010/100011 SUB
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR
  - 101010 SLT, 101011 SLTU
  - 000000 SLL, 000010 SRL, 000011 SRA
  - Any other funct is caught in DECODE → TRAP.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- EXEC_I: src_a=1, src_b=10. Opcode → sel:
  - addi/addiu ADD, andi AND, ori OR, xori XOR, slti SLT, sltiu SLTU
  - imm_zext=1 only for andi/ori/xori
- WB_I: reg_write=1, reg_dst=0 → FETCH.
- MEM_ADDR: ADD, src_a=1, src_b=10 → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD / MEM_WR: mem_req=1, iord=1, mem_we=1 in MEM_WR only. Hold until mem_ready. Then MEM_RD → WB_MEM; MEM_WR → FETCH.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- BRANCH: SUB, src_a=1, src_b=00, pc_src=01. pc_write = (beq & zero) | (bne & ~zero) (Mealy on zero). → FETCH.
- JUMP: pc_src=10, pc_write=1 → FETCH.
- TRAP: all strobes 0, mem_req=0. Held until reset.
- Timeout: a wait counter increments each cycle mem_req=1 & ~mem_ready, and clears on mem_ready or on state change. When it reaches MEM_TIMEOUT → TRAP with bus_error=1.
- instr_count: +1 (wraps at 2^32) on the last cycle of each instruction — WB_R, WB_I, WB_MEM, MEM_WR with mem_ready, BRANCH, JUMP.
- Unlisted outputs are 0 in each state. alu_sel defaults to ADD.

## Timing
- Reset: any rising edge with rst_n=0 gives state=FETCH, wait counter 0, illegal_instr=0, bus_error=0, instr_count=0. This applies mid-instruction too: no strobe is issued in the reset cycle.
- While rst_n=0, all strobes and mem_req are forced 0 and alu_sel=ADD.
- Outputs are decoded combinationally from state, plus mem_ready/zero where stated.
- Cycle counts with zero-wait memory (mem_ready=1 on the first request cycle): R/I-type 4, lw 5, sw 4, beq/bne 3, j 3. Each memory wait cycle adds 1.
- mem_req stays high continuously until the mem_ready cycle, and drops the next cycle unless the following state also requests.

## Structure
- mips_pkg holds the ALU select localparams, the opcode/funct constants and the state enum.
- Sub-module alu_sel_decode is purely combinational: (state class, opcode, funct) → alu_sel, imm_zext, legal.
- mips_multicycle_ctrl holds the state register, the wait counter, the sticky flags and instr_count.

## Test plan
- add 000000/100000, mem_ready=1 → FETCH, DECODE, EXEC_R (alu_sel=00010), WB_R (reg_write=1, reg_dst=1); instr_count=1 after 4 cycles.
- lw with mem_ready delayed 3 cycles in MEM_RD → mem_req/iord high 4 cycles; WB_MEM mem_to_reg=1; total 8 cycles.
- beq with zero=1 → pc_write=1, pc_src=01 in BRANCH. bne with zero=1 → pc_write=0.
- sra 000000/000011 → alu_sel=01010. andi → alu_sel=00000, imm_zext=1. sltiu → 01011, imm_zext=0.
- opcode 111111 → TRAP, illegal_instr=1, all strobes 0 thereafter; rst_n=0 one cycle → FETCH, flag cleared.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → bus_error=1, TRAP after 4 wait cycles. rst_n=0 mid-MEM_WR → no mem_we next cycle, instr_count=0.
